// File: rtl/riscv_ai_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ai_pkg
// Brief    : Shared encodings for the EX stage: ALU ops, AI ops, FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_ai_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] AI_MAC     = 3'd0;
    localparam logic [2:0] AI_DOT4    = 3'd1;
    localparam logic [2:0] AI_RELU    = 3'd2;
    localparam logic [2:0] AI_ACC_CLR = 3'd3;
    localparam logic [2:0] AI_ACC_RD  = 3'd4;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ai_state_t;

endpackage
`default_nettype wire

// File: rtl/ai_mac_unit.sv
`default_nettype none
// ============================================================================
// Module   : ai_mac_unit
// Brief    : Accumulator, operand latches and IDLE/BUSY FSM for MAC and DOT4.
// Revision : 1.0 - initial release
// ============================================================================
module ai_mac_unit
    import riscv_ai_pkg::*;
#(
    parameter int AI_LATENCY = 3,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic            i_is_dot,
    input  logic            i_acc_clr,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_stall,
    output logic            o_done,
    output logic            o_busy,
    output logic [XLEN-1:0] o_result,
    output logic [XLEN-1:0] o_acc
);

    localparam logic       c_multi    = (AI_LATENCY > 1);
    localparam logic [3:0] c_cnt_load = (AI_LATENCY > 1) ? 4'(AI_LATENCY - 2) : 4'd0;

    ai_state_t         r_state;
    logic [3:0]        r_cnt;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_op_a;
    logic [XLEN-1:0]   r_op_b;
    logic              r_is_dot;

    logic              w_busy;
    logic [XLEN-1:0]   w_op_a;
    logic [XLEN-1:0]   w_op_b;
    logic              w_is_dot;
    logic [XLEN-1:0]   w_mac;
    logic signed [7:0]  w_lane_a;
    logic signed [7:0]  w_lane_b;
    logic signed [15:0] w_lane_p;
    logic signed [17:0] w_dot;

    assign w_busy   = (r_state == ST_BUSY);
    // Single-cycle latency completes in IDLE straight from the live operands
    assign w_op_a   = w_busy ? r_op_a   : i_rs1;
    assign w_op_b   = w_busy ? r_op_b   : i_rs2;
    assign w_is_dot = w_busy ? r_is_dot : i_is_dot;
    assign w_mac    = r_acc + w_op_a * w_op_b;

    always_comb begin
        w_dot    = '0;
        w_lane_a = '0;
        w_lane_b = '0;
        w_lane_p = '0;
        for (int i = 0; i < 4; i++) begin
            w_lane_a = w_op_a[8*i +: 8];
            w_lane_b = w_op_b[8*i +: 8];
            w_lane_p = w_lane_a * w_lane_b;
            w_dot    = w_dot + 18'(w_lane_p);
        end
    end

    assign o_result = w_is_dot ? {{(XLEN-18){w_dot[17]}}, w_dot} : w_mac;
    assign o_done   = !i_flush && (w_busy ? (r_cnt == 4'd0) : (i_start && !c_multi));
    assign o_stall  = !i_flush && (w_busy ? (r_cnt != 4'd0) : (i_start && c_multi));
    assign o_busy   = w_busy;
    assign o_acc    = r_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_acc    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_is_dot <= 1'b0;
        end else if (i_flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (c_multi) begin
                            r_op_a   <= i_rs1;
                            r_op_b   <= i_rs2;
                            r_is_dot <= i_is_dot;
                            r_cnt    <= c_cnt_load;
                            r_state  <= ST_BUSY;
                        end else if (!i_is_dot) begin
                            r_acc <= w_mac;
                        end
                    end else if (i_acc_clr) begin
                        r_acc <= '0;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= ST_IDLE;
                        if (!r_is_dot) begin
                            r_acc <= w_mac;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage_ai.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_ai
// Brief    : Execute stage with integer ALU, AI extension and EX/MEM register.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage_ai
    import riscv_ai_pkg::*;
#(
    parameter int AI_LATENCY = 3,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_in,
    input  logic            flush_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] read_data1_in,
    input  logic [XLEN-1:0] read_data2_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [3:0]      alu_op_in,
    input  logic [4:0]      rd_in,
    input  logic            regwrite_in,
    input  logic            is_ai_in,
    input  logic [2:0]      ai_opcode_in,
    input  logic [6:0]      op_in,
    output logic            stall_out,
    output logic [XLEN-1:0] result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rd_out,
    output logic            regwrite_out,
    output logic [6:0]      op_out,
    output logic            valid_out,
    output logic            ai_busy_out
);

    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_alu_res;
    logic [XLEN-1:0] w_single_res;
    logic            w_is_multi;
    logic            w_start;
    logic            w_acc_clr;
    logic            w_stall;
    logic            w_done;
    logic            w_busy;
    logic [XLEN-1:0] w_unit_res;
    logic [XLEN-1:0] w_acc;

    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_store;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_rd;
    logic            r_regwrite;
    logic [6:0]      r_op;
    logic            r_valid;

    assign w_op_b     = (op_in == OP_RTYPE) ? read_data2_in : imm_in;
    assign w_is_multi = is_ai_in && ((ai_opcode_in == AI_MAC) || (ai_opcode_in == AI_DOT4));
    assign w_start    = valid_in && w_is_multi && !flush_in && !w_busy;
    assign w_acc_clr  = valid_in && is_ai_in && (ai_opcode_in == AI_ACC_CLR) && !flush_in && !w_busy;

    ai_mac_unit #(
        .AI_LATENCY (AI_LATENCY),
        .XLEN       (XLEN)
    ) u_ai_mac_unit (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_start   (w_start),
        .i_flush   (flush_in),
        .i_is_dot  (ai_opcode_in == AI_DOT4),
        .i_acc_clr (w_acc_clr),
        .i_rs1     (read_data1_in),
        .i_rs2     (read_data2_in),
        .o_stall   (w_stall),
        .o_done    (w_done),
        .o_busy    (w_busy),
        .o_result  (w_unit_res),
        .o_acc     (w_acc)
    );

    always_comb begin
        w_alu_res = '0;
        case (alu_op_in)
            ALU_ADD:  w_alu_res = read_data1_in + w_op_b;
            ALU_SUB:  w_alu_res = read_data1_in - w_op_b;
            ALU_AND:  w_alu_res = read_data1_in & w_op_b;
            ALU_OR:   w_alu_res = read_data1_in | w_op_b;
            ALU_XOR:  w_alu_res = read_data1_in ^ w_op_b;
            ALU_SLL:  w_alu_res = read_data1_in << w_op_b[4:0];
            ALU_SRL:  w_alu_res = read_data1_in >> w_op_b[4:0];
            ALU_SRA:  w_alu_res = $signed(read_data1_in) >>> w_op_b[4:0];
            ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(read_data1_in) < $signed(w_op_b)};
            ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, read_data1_in < w_op_b};
            default:  w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_single_res = w_alu_res;
        if (is_ai_in) begin
            case (ai_opcode_in)
                AI_RELU:   w_single_res = read_data1_in[XLEN-1] ? '0 : read_data1_in;
                AI_ACC_RD: w_single_res = w_acc;
                default:   w_single_res = '0;
            endcase
        end
    end

    // EX/MEM register; every bubble is an all-zero slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result   <= '0;
            r_store    <= '0;
            r_pc       <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_op       <= '0;
            r_valid    <= 1'b0;
        end else if (w_done || (valid_in && !flush_in && !w_stall)) begin
            r_result   <= w_done ? w_unit_res : w_single_res;
            r_store    <= read_data2_in;
            r_pc       <= pc_in;
            r_rd       <= rd_in;
            r_regwrite <= regwrite_in;
            r_op       <= op_in;
            r_valid    <= 1'b1;
        end else begin
            r_result   <= '0;
            r_store    <= '0;
            r_pc       <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_op       <= '0;
            r_valid    <= 1'b0;
        end
    end

    assign stall_out      = w_stall && reset_n;
    assign result_out     = r_result;
    assign store_data_out = r_store;
    assign pc_out         = r_pc;
    assign rd_out         = r_rd;
    assign regwrite_out   = r_regwrite;
    assign op_out         = r_op;
    assign valid_out      = r_valid;
    assign ai_busy_out    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_ai.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_ai
// Brief    : Scoreboard bench for ex_stage_ai at AI_LATENCY 3 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage_ai;

    localparam logic [6:0] c_op_r  = 7'b0110011;
    localparam logic [6:0] c_op_i  = 7'b0010011;
    localparam logic [6:0] c_op_ai = 7'b0001011;

    typedef struct {
        logic [31:0] res;
        logic [31:0] pc;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        rw;
        logic [6:0]  op;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in, valid1, flush_in, regwrite_in, is_ai_in;
    logic [31:0] pc_in, rs1, rs2, imm_in;
    logic [3:0]  alu_op_in;
    logic [4:0]  rd_in;
    logic [2:0]  ai_opcode_in;
    logic [6:0]  op_in;

    logic        stall_out, regwrite_out, valid_out, ai_busy_out;
    logic [31:0] result_out, store_data_out, pc_out;
    logic [4:0]  rd_out;
    logic [6:0]  op_out;

    logic        stall1, regwrite1, valid1_out, busy1;
    logic [31:0] result1, store1, pc1;
    logic [4:0]  rd1;
    logic [6:0]  op1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   k = 0;

    always #5 clk = ~clk;

    ex_stage_ai #(.AI_LATENCY(3), .XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .flush_in(flush_in),
        .pc_in(pc_in), .read_data1_in(rs1), .read_data2_in(rs2), .imm_in(imm_in),
        .alu_op_in(alu_op_in), .rd_in(rd_in), .regwrite_in(regwrite_in),
        .is_ai_in(is_ai_in), .ai_opcode_in(ai_opcode_in), .op_in(op_in),
        .stall_out(stall_out), .result_out(result_out), .store_data_out(store_data_out),
        .pc_out(pc_out), .rd_out(rd_out), .regwrite_out(regwrite_out), .op_out(op_out),
        .valid_out(valid_out), .ai_busy_out(ai_busy_out)
    );

    ex_stage_ai #(.AI_LATENCY(1), .XLEN(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .valid_in(valid1), .flush_in(flush_in),
        .pc_in(pc_in), .read_data1_in(rs1), .read_data2_in(rs2), .imm_in(imm_in),
        .alu_op_in(alu_op_in), .rd_in(rd_in), .regwrite_in(regwrite_in),
        .is_ai_in(is_ai_in), .ai_opcode_in(ai_opcode_in), .op_in(op_in),
        .stall_out(stall1), .result_out(result1), .store_data_out(store1),
        .pc_out(pc1), .rd_out(rd1), .regwrite_out(regwrite1), .op_out(op1),
        .valid_out(valid1_out), .ai_busy_out(busy1)
    );

    // Monitors: pop one expectation per valid EX/MEM slot
    always @(negedge clk) begin
        if (reset_n && valid_out) begin
            n_vec++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL lat3_unexpected_output actual=%h required=no output", result_out);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if ({result_out, pc_out, store_data_out, rd_out, regwrite_out, op_out} !==
                    {e.res, e.pc, e.store, e.rd, e.rw, e.op}) begin
                    n_err++;
                    $display("FAIL lat3_vector actual res=%h pc=%h st=%h rd=%0d rw=%b op=%b required res=%h pc=%h st=%h rd=%0d rw=%b op=%b",
                             result_out, pc_out, store_data_out, rd_out, regwrite_out, op_out,
                             e.res, e.pc, e.store, e.rd, e.rw, e.op);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && valid1_out) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL lat1_unexpected_output actual=%h required=no output", result1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if ({result1, pc1, store1, rd1, regwrite1, op1} !==
                    {e.res, e.pc, e.store, e.rd, e.rw, e.op}) begin
                    n_err++;
                    $display("FAIL lat1_vector actual res=%h pc=%h st=%h rd=%0d rw=%b op=%b required res=%h pc=%h st=%h rd=%0d rw=%b op=%b",
                             result1, pc1, store1, rd1, regwrite1, op1,
                             e.res, e.pc, e.store, e.rd, e.rw, e.op);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic on_lat1, input logic ai, input logic [2:0] aop,
                         input logic [3:0] alu, input logic [6:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        pc_in        = 32'h1000 + 32'(4 * k);
        rd_in        = 5'(k);
        k++;
        regwrite_in  = 1'b1;
        valid_in     = !on_lat1;
        valid1       = on_lat1;
        is_ai_in     = ai;
        ai_opcode_in = aop;
        alu_op_in    = alu;
        op_in        = op;
        rs1          = a;
        rs2          = b;
        imm_in       = im;
    endtask

    // Entered and left at 1 time unit after a rising edge
    task automatic run_op(input logic on_lat1, input logic ai, input logic [2:0] aop,
                          input logic [3:0] alu, input logic [6:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                          input logic [31:0] exp_res, input int exp_stall);
        exp_t e;
        int   n;
        drive(on_lat1, ai, aop, alu, op, a, b, im);
        e.res = exp_res; e.pc = pc_in; e.store = b; e.rd = rd_in; e.rw = 1'b1; e.op = op;
        if (on_lat1) q1.push_back(e);
        else         q0.push_back(e);
        #1;
        n = 0;
        while ((on_lat1 ? stall1 : stall_out) && n < 20) begin
            n++;
            @(posedge clk); #1;
            chk("stall_bubble_valid", {31'd0, on_lat1 ? valid1_out : valid_out}, 32'd0);
        end
        chk(on_lat1 ? "lat1_stall_cycles" : "lat3_stall_cycles", 32'(n), 32'(exp_stall));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; valid_in = 1'b0; valid1 = 1'b0; flush_in = 1'b0;
        pc_in = '0; rs1 = '0; rs2 = '0; imm_in = '0; alu_op_in = '0; rd_in = '0;
        regwrite_in = 1'b0; is_ai_in = 1'b0; ai_opcode_in = '0; op_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, valid_out}, 32'd0);
        chk("reset_result", result_out, 32'd0);
        chk("reset_regwrite", {31'd0, regwrite_out}, 32'd0);
        chk("reset_busy", {31'd0, ai_busy_out}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ALU
        run_op(0, 0, 3'd0, 4'd0, c_op_r, 32'd7, 32'hFFFFFFFF, 32'd0, 32'd6, 0);
        run_op(0, 0, 3'd0, 4'd1, c_op_r, 32'd5, 32'd7, 32'd0, 32'hFFFFFFFE, 0);
        run_op(0, 0, 3'd0, 4'd7, c_op_i, 32'h80000000, 32'h55, 32'd4, 32'hF8000000, 0);
        run_op(0, 0, 3'd0, 4'd8, c_op_i, 32'hFFFFFFFF, 32'h0, 32'd1, 32'd1, 0);
        run_op(0, 0, 3'd0, 4'd9, c_op_r, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd1, 0);
        run_op(0, 0, 3'd0, 4'd15, c_op_r, 32'd9, 32'd3, 32'd0, 32'd0, 0);

        // MAC / DOT4 at latency 3
        run_op(0, 1, 3'd0, 4'd0, c_op_ai, 32'd3, 32'd4, 32'd0, 32'd12, 2);
        run_op(0, 1, 3'd0, 4'd0, c_op_ai, 32'hFFFFFFFE, 32'd5, 32'd0, 32'd2, 2);
        run_op(0, 1, 3'd1, 4'd0, c_op_ai, 32'h01FF7F80, 32'h02020202, 32'd0, 32'hFFFFFFFE, 2);
        run_op(0, 1, 3'd4, 4'd0, c_op_ai, 32'd0, 32'd0, 32'd0, 32'd2, 0);

        // Flush in the second cycle of a MAC
        drive(0, 1, 3'd0, 4'd0, c_op_ai, 32'd3, 32'd4, 32'd0);
        #1 chk("flush_start_stall", {31'd0, stall_out}, 32'd1);
        @(posedge clk); #1;
        flush_in = 1'b1;
        #1 chk("flush_stall_drop", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        flush_in = 1'b0;
        chk("flush_no_valid", {31'd0, valid_out}, 32'd0);
        chk("flush_idle", {31'd0, ai_busy_out}, 32'd0);
        run_op(0, 1, 3'd4, 4'd0, c_op_ai, 32'd0, 32'd0, 32'd0, 32'd2, 0);

        // Invalid slot with regwrite set
        drive(0, 0, 3'd0, 4'd0, c_op_r, 32'd1, 32'd2, 32'd0);
        valid_in = 1'b0;
        @(posedge clk); #1;
        chk("invalid_valid", {31'd0, valid_out}, 32'd0);
        chk("invalid_regwrite", {31'd0, regwrite_out}, 32'd0);

        // Asynchronous reset while BUSY
        drive(0, 1, 3'd0, 4'd0, c_op_ai, 32'd3, 32'd4, 32'd0);
        @(posedge clk); #1;
        chk("busy_before_reset", {31'd0, ai_busy_out}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, ai_busy_out}, 32'd0);
        chk("async_reset_valid", {31'd0, valid_out}, 32'd0);
        chk("async_reset_result", result_out, 32'd0);
        chk("async_reset_stall", {31'd0, stall_out}, 32'd0);
        valid_in = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 1, 3'd4, 4'd0, c_op_ai, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        run_op(0, 1, 3'd2, 4'd0, c_op_ai, 32'h80000001, 32'd0, 32'd0, 32'd0, 0);
        run_op(0, 1, 3'd2, 4'd0, c_op_ai, 32'd5, 32'd0, 32'd0, 32'd5, 0);
        run_op(0, 1, 3'd0, 4'd0, c_op_ai, 32'd1, 32'd7, 32'd0, 32'd7, 2);
        run_op(0, 1, 3'd3, 4'd0, c_op_ai, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        run_op(0, 1, 3'd4, 4'd0, c_op_ai, 32'd0, 32'd0, 32'd0, 32'd0, 0);

        // Latency-1 instance: no stall, result in one cycle
        run_op(1, 1, 3'd0, 4'd0, c_op_ai, 32'd6, 32'd7, 32'd0, 32'd42, 0);
        run_op(1, 1, 3'd0, 4'd0, c_op_ai, 32'd2, 32'd3, 32'd0, 32'd48, 0);
        run_op(1, 1, 3'd1, 4'd0, c_op_ai, 32'h01FF7F80, 32'h02020202, 32'd0, 32'hFFFFFFFE, 0);
        run_op(1, 1, 3'd4, 4'd0, c_op_ai, 32'd0, 32'd0, 32'd0, 32'd48, 0);

        valid_in = 1'b0;
        valid1   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lat3_queue_drained", 32'(q0.size()), 32'd0);
        chk("lat1_queue_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
